// File: rtl/fp_mult_seq.sv
// Sequential floating-point multiplier: radix-2 shift-add significand product, RNE rounding,
// DAZ/flush-to-zero, special-operand handling and exception flags, valid/ready on both sides.
module fp_mult_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned M     = MAN_W + 1;
    localparam int unsigned CNT_W = $clog2(M);
    localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX  = (1 << EXP_W) - 1;
    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W + 2)'(BIAS);
    localparam logic signed [EXP_W+1:0] EMAX_S = (EXP_W + 2)'(EMAX);
    localparam logic signed [EXP_W+1:0] ZERO_S = '0;

    typedef enum logic [1:0] {Idle, Mul, Norm, Done} stateT;

    stateT              state;
    logic [CNT_W-1:0]   cnt;
    logic [2*M-1:0]     acc;
    logic [M-1:0]       mcand;
    logic [M-1:0]       mplr;
    logic               signR;
    logic [EXP_W-1:0]   expA;
    logic [EXP_W-1:0]   expB;
    logic               nanA, nanB, infA, infB, zeroA, zeroB;

    logic [EXP_W-1:0]   inExpA, inExpB;
    logic [MAN_W-1:0]   inFracA, inFracB;

    logic [M-1:0]       addend;
    logic [M:0]         addSum;
    logic [2*M-1:0]     accNext;

    logic               normBit;
    logic [MAN_W-1:0]   kept;
    logic               guardBit;
    logic               stickyBit;
    logic               roundUp;
    logic [MAN_W:0]     rounded;
    logic               roundCarry;
    logic signed [EXP_W+1:0] expSum;
    logic [W-1:0]       resD;
    logic [3:0]         flagsD;

    always_comb begin
        inExpA  = a[W-2:MAN_W];
        inExpB  = b[W-2:MAN_W];
        inFracA = a[MAN_W-1:0];
        inFracB = b[MAN_W-1:0];
    end

    // One shift-add step: add into the upper half, then shift the whole accumulator right.
    always_comb begin
        addend  = mplr[0] ? mcand : '0;
        addSum  = {1'b0, acc[2*M-1:M]} + {1'b0, addend};
        accNext = {addSum, acc[M-1:1]};
    end

    always_comb begin
        normBit = acc[2*M-1];
        if (normBit) begin
            kept      = acc[2*M-2:M];
            guardBit  = acc[M-1];
            stickyBit = |acc[M-2:0];
        end else begin
            kept      = acc[2*M-3:M-1];
            guardBit  = acc[M-2];
            stickyBit = |acc[M-3:0];
        end
        roundUp    = guardBit & (stickyBit | kept[0]);
        rounded    = {1'b0, kept} + {{MAN_W{1'b0}}, roundUp};
        roundCarry = rounded[MAN_W];
        expSum     = $signed({2'b00, expA}) + $signed({2'b00, expB}) - BIAS_S
                   + $signed({{(EXP_W + 1){1'b0}}, normBit})
                   + $signed({{(EXP_W + 1){1'b0}}, roundCarry});

        resD   = {signR, expSum[EXP_W-1:0], rounded[MAN_W-1:0]};
        flagsD = {3'b000, guardBit | stickyBit};
        if (nanA || nanB || (infA && zeroB) || (infB && zeroA)) begin
            resD   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
            flagsD = 4'b1000;
        end else if (infA || infB) begin
            resD   = {signR, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flagsD = 4'b0000;
        end else if (zeroA || zeroB) begin
            resD   = {signR, {(W - 1){1'b0}}};
            flagsD = 4'b0000;
        end else if (expSum >= EMAX_S) begin
            resD   = {signR, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flagsD = 4'b0101;
        end else if (expSum <= ZERO_S) begin
            resD   = {signR, {(W - 1){1'b0}}};
            flagsD = 4'b0011;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= Idle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            signR     <= 1'b0;
            expA      <= '0;
            expB      <= '0;
            nanA      <= 1'b0;
            nanB      <= 1'b0;
            infA      <= 1'b0;
            infB      <= 1'b0;
            zeroA     <= 1'b0;
            zeroB     <= 1'b0;
        end else begin
            case (state)
                Idle: begin
                    if (in_valid) begin
                        signR    <= a[W-1] ^ b[W-1];
                        expA     <= inExpA;
                        expB     <= inExpB;
                        mcand    <= {1'b1, inFracA};
                        mplr     <= {1'b1, inFracB};
                        zeroA    <= (inExpA == '0);
                        zeroB    <= (inExpB == '0);
                        infA     <= (inExpA == '1) && (inFracA == '0);
                        infB     <= (inExpB == '1) && (inFracB == '0);
                        nanA     <= (inExpA == '1) && (inFracA != '0);
                        nanB     <= (inExpB == '1) && (inFracB != '0);
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= Mul;
                    end
                end
                Mul: begin
                    acc  <= accNext;
                    mplr <= mplr >> 1;
                    if (cnt == CNT_W'(M - 1)) begin
                        state <= Norm;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                Norm: begin
                    result    <= resD;
                    flags     <= flagsD;
                    out_valid <= 1'b1;
                    state     <= Done;
                end
                Done: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= Idle;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_seq.sv
// Bench for fp_mult_seq (FP32): directed corner cases, backpressure, mid-op reset and
// random operands checked against an integer-arithmetic reference model.
module tb_fp_mult_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [3:0]  flags;

    int total = 0;
    int bad = 0;

    fp_mult_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Exact significand product as a 48-bit integer, rounded by comparing the remainder to half.
    function automatic void refModel(input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] r, output logic [3:0] f);
        logic   s;
        int     ex, ey, e, sh;
        longint mx, my, p, kept, rem, half;
        bit     zx, zy, ix, iy, nx, ny;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        if (nx || ny || (ix && zy) || (iy && zx)) begin
            r = 32'h7FC00000; f = 4'b1000; return;
        end
        if (ix || iy) begin
            r = {s, 8'hFF, 23'h0}; f = 4'b0000; return;
        end
        if (zx || zy) begin
            r = {s, 31'h0}; f = 4'b0000; return;
        end
        mx = 64'(x[22:0]) + 64'h800000;
        my = 64'(y[22:0]) + 64'h800000;
        p  = mx * my;
        e  = ex + ey - 127;
        if (p >= (64'd1 << 47)) begin
            sh = 24; e++;
        end else begin
            sh = 23;
        end
        half = 64'd1 << (sh - 1);
        kept = p >> sh;
        rem  = p - (kept << sh);
        if (rem > half || (rem == half && kept[0])) kept++;
        if (kept == (64'd1 << 24)) begin
            kept = kept >> 1; e++;
        end
        if (e >= 255) begin
            r = {s, 8'hFF, 23'h0}; f = 4'b0101;
        end else if (e <= 0) begin
            r = {s, 31'h0}; f = 4'b0011;
        end else begin
            r = {s, e[7:0], kept[22:0]}; f = {3'b000, rem != 0};
        end
    endfunction

    function automatic logic [31:0] randOp();
        logic [31:0] fr;
        logic [7:0]  e;
        int          sel;
        sel = $urandom_range(0, 15);
        fr  = $urandom;
        if (sel == 0)      e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else               e = 8'($urandom_range(40, 214));
        if (sel == 1 && $urandom_range(0, 1) == 0) fr = '0;
        return {1'($urandom_range(0, 1)), e, fr[22:0]};
    endfunction

    task automatic runOp(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic [3:0] ef, input int hold);
        int lat;
        @(negedge clk);
        a = x; b = y; in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd25);
        check({tag, "_result"}, result, er);
        check({tag, "_flags"}, 32'(flags), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_result"}, result, er);
            check({tag, "_hold_flags"}, 32'(flags), 32'(ef));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_in_ready"}, 32'(in_ready), 32'd1);
        if (hold > 0) begin
            repeat (2) @(posedge clk);
            #1;
            check({tag, "_no_phantom"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] x, y, er;
        logic [3:0]  ef;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;

        runOp("mul3x2p5", 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 0);
        runOp("rne_tie", 32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001, 0);
        runOp("overflow", 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 0);
        runOp("inf_x_0", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 0);
        runOp("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 0);
        runOp("underflow_neg", 32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011, 0);
        runOp("nan_in", 32'h7FA00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 0);
        runOp("inf_x_neg", 32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 0);
        runOp("zero_x_neg", 32'h00000000, 32'hC1200000, 32'h80000000, 4'b0000, 0);
        runOp("daz", 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 0);
        runOp("backpressure", 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 10);

        // Abort five cycles into the multiply phase.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("after_abort", 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 0);

        for (int i = 0; i < 40; i++) begin
            x = randOp();
            y = randOp();
            refModel(x, y, er, ef);
            runOp($sformatf("rand%0d", i), x, y, er, ef, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
